// File: rtl/swap_datapath.sv
// Three-register swap datapath sharing one internal bus, with bus
// contention/float detection, an external write port and a swap counter.
module swap_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c1,
  input  logic             c2,
  input  logic             c3,
  input  logic             h1,
  input  logic             h2,
  input  logic             h3,
  input  logic             done,
  input  logic             ext_load,
  input  logic [1:0]       ext_sel,
  input  logic [WIDTH-1:0] ext_data,
  output logic [WIDTH-1:0] r1_q,
  output logic [WIDTH-1:0] r2_q,
  output logic [WIDTH-1:0] r3_q,
  output logic [WIDTH-1:0] bus,
  output logic             bus_err,
  output logic             float_err,
  output logic             ext_drop,
  output logic [7:0]       swap_count,
  output logic             result_valid
);

  logic [WIDTH-1:0] r1_d, r2_d, r3_d;
  logic             bus_err_q, bus_err_d;
  logic             float_err_q, float_err_d;
  logic             ext_drop_q, ext_drop_d;
  logic [7:0]       swap_count_q, swap_count_d;
  logic             result_valid_q, result_valid_d;

  logic [1:0]       h_cnt;
  logic             contention;
  logic             floating;
  logic             cap_ok;
  logic             sel1, sel2, sel3;

  assign bus_err      = bus_err_q;
  assign float_err    = float_err_q;
  assign ext_drop     = ext_drop_q;
  assign swap_count   = swap_count_q;
  assign result_valid = result_valid_q;

  always_comb begin
    h_cnt = {1'b0, h1} + {1'b0, h2} + {1'b0, h3};
    case ({h3, h2, h1})
      3'b001:  bus = r1_q;
      3'b010:  bus = r2_q;
      3'b100:  bus = r3_q;
      default: bus = '0;
    endcase
    contention = (h_cnt >= 2'd2);
    floating   = (c1 | c2 | c3) && (h_cnt == 2'd0);
    cap_ok     = !contention && !floating;

    sel1 = ext_load && (ext_sel == 2'd1);
    sel2 = ext_load && (ext_sel == 2'd2);
    sel3 = ext_load && (ext_sel == 2'd3);

    // A high capture enable owns its register even when suppressed,
    // so an external write to it is lost.
    r1_d = r1_q;
    if (c1) begin
      if (cap_ok) r1_d = bus;
    end else if (sel1) begin
      r1_d = ext_data;
    end

    r2_d = r2_q;
    if (c2) begin
      if (cap_ok) r2_d = bus;
    end else if (sel2) begin
      r2_d = ext_data;
    end

    r3_d = r3_q;
    if (c3) begin
      if (cap_ok) r3_d = bus;
    end else if (sel3) begin
      r3_d = ext_data;
    end

    ext_drop_d     = (sel1 && c1) || (sel2 && c2) || (sel3 && c3);
    bus_err_d      = bus_err_q | contention;
    float_err_d    = float_err_q | floating;
    swap_count_d   = swap_count_q + {7'd0, done};
    result_valid_d = done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q           <= '0;
      r2_q           <= '0;
      r3_q           <= '0;
      bus_err_q      <= 1'b0;
      float_err_q    <= 1'b0;
      ext_drop_q     <= 1'b0;
      swap_count_q   <= 8'd0;
      result_valid_q <= 1'b0;
    end else begin
      r1_q           <= r1_d;
      r2_q           <= r2_d;
      r3_q           <= r3_d;
      bus_err_q      <= bus_err_d;
      float_err_q    <= float_err_d;
      ext_drop_q     <= ext_drop_d;
      swap_count_q   <= swap_count_d;
      result_valid_q <= result_valid_d;
    end
  end

endmodule

// File: doc/swap_datapath.md
SWAP_DATAPATH -- requirements
Module: swap_datapath

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width of the three registers and the bus.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports c1, c2, c3, inputs, 1 bit each: capture enables; c_i loads the bus into R_i.
REQ-005 The block SHALL have ports h1, h2, h3, inputs, 1 bit each: drive enables; h_i places R_i on the bus.
REQ-006 The block SHALL have port done, input, 1 bit: swap-complete pulse from the swap controller.
REQ-007 The block SHALL have ports ext_load (input, 1 bit), ext_sel (input, 2 bits) and ext_data (input, WIDTH): external register write; ext_sel 1/2/3 selects R1/R2/R3, and 0 is ignored.
REQ-008 The block SHALL have ports r1_q, r2_q, r3_q, outputs, WIDTH each: register contents.
REQ-009 The block SHALL have port bus, output, WIDTH: combinational internal bus value.
REQ-010 The block SHALL have ports bus_err and float_err, outputs, 1 bit each: sticky error flags.
REQ-011 The block SHALL have port ext_drop, output, 1 bit: registered one-cycle pulse indicating an external write was lost.
REQ-012 The block SHALL have ports swap_count (output, 8 bits) and result_valid (output, 1 bit): completed-swap counter and registered completion pulse.

Function
REQ-013 bus SHALL equal R_i when exactly one h_i is high, and SHALL be all-zeros otherwise.
REQ-014 When two or more h_i are high (contention), all captures SHALL be suppressed that cycle and bus_err SHALL be set on the next edge.
REQ-015 When any c_i is high and no h_i is high (floating bus), all captures SHALL be suppressed that cycle and float_err SHALL be set on the next edge.
REQ-016 Otherwise, each R_i with c_i high SHALL load bus on the rising edge; multiple simultaneous captures are legal and load the same value.
REQ-017 Capture and drive of the same register in one cycle (c_i and h_i) SHALL leave R_i unchanged, since it reloads its own value.
REQ-018 When ext_load is high, ext_sel is nonzero and the selected c_i is low, the selected register SHALL load ext_data on the edge.
REQ-019 When ext_load targets a register whose c_i is high, the capture SHALL win even if suppressed; the external write SHALL be dropped and ext_drop SHALL pulse high for exactly one cycle.
REQ-020 ext_load with ext_sel = 0 SHALL have no effect and SHALL NOT raise ext_drop.
REQ-021 bus_err and float_err SHALL remain set until reset.
REQ-022 When done is high on an edge, swap_count SHALL increment by 1, modulo 256 (255 wraps to 0).
REQ-023 result_valid SHALL be high for the cycle following each cycle in which done is high; back-to-back done SHALL give back-to-back result_valid.
REQ-024 done SHALL be counted regardless of error flags.
REQ-025 Register-update latency SHALL be one clock; bus SHALL have zero latency.

Reset
REQ-026 With reset high on an edge: R1, R2 and R3 SHALL be 0; swap_count SHALL be 0; bus_err, float_err, ext_drop and result_valid SHALL be 0.
REQ-027 Reset SHALL take priority over every capture, external load and done input in the same cycle.
REQ-028 Reset asserted mid-swap SHALL abandon the swap with no partial state retained.

Verification
REQ-029 Scenario, load and swap: load R1=0x11 and R2=0x22 via ext_load, then drive the sequence h1/c3, h2/c1, h3/c2 followed by a done pulse -> R1=0x22, R2=0x11, R3=0x11, swap_count=1, result_valid high one cycle after done.
REQ-030 Scenario, contention: set h1=h2=1 with c3=1 while R3=0x33 -> bus=0, R3 stays 0x33, bus_err=1 and stays high until reset.
REQ-031 Scenario, floating bus: set c2=1 with no h asserted while R2=0x44 -> R2 stays 0x44, float_err=1.
REQ-032 Scenario, write collision: ext_load=1, ext_sel=1, ext_data=0xAA, with h2=1, c1=1 and R2=0x55 -> R1=0x55, ext_drop pulses for one cycle.
REQ-033 Scenario, counter wrap: apply 256 done pulses from reset -> swap_count reads 255 after the 255th pulse and 0 after the 256th.
REQ-034 Scenario, reset mid-operation: assert reset in the same cycle as c1/h2 and done -> all registers, swap_count and flags read 0 the next cycle.
